diy_mole_recorder: RTL and testbench

//  Writer side of the DIY mole table. In DIY record mode it captures {music_address, mole location}

---
 rtl/diy_mole_recorder_pkg.sv | 34 +++
 rtl/diy_mole_recorder_table.sv | 32 +++
 rtl/diy_mole_recorder.sv | 143 ++++++++++++++
 tb/tb_diy_mole_recorder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/diy_mole_recorder_pkg.sv
// ============================================================================
// diy_mole_recorder_pkg : shared encodings for the DIY mole recorder slice
// Rev 1.0
// ============================================================================
`default_nettype none

package diy_mole_recorder_pkg;

  localparam int PKG_ADDR_BITS = 23;

  // Game-state encodings used by the surrounding game FSM
  localparam logic [3:0] GS_DIY_DONE_RECORD        = 4'd11;
  localparam logic [3:0] GS_RECORD_DIY_IN_PROGRESS = 4'd12;

  // Location codes; pad bit for location L is pads[7-L]
  localparam logic [2:0] LOC_UPLEFT    = 3'd0;
  localparam logic [2:0] LOC_UP        = 3'd1;
  localparam logic [2:0] LOC_UPRIGHT   = 3'd2;
  localparam logic [2:0] LOC_LEFT      = 3'd3;
  localparam logic [2:0] LOC_RIGHT     = 3'd4;
  localparam logic [2:0] LOC_DOWNLEFT  = 3'd5;
  localparam logic [2:0] LOC_DOWN      = 3'd6;
  localparam logic [2:0] LOC_DOWNRIGHT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ARMED        = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_DONE         = 2'd3
  } rec_state_t;

endpackage

`default_nettype wire

// File: rtl/diy_mole_recorder_table.sv
// ============================================================================
// diy_mole_table : simple dual-port RAM, sync write, registered read-first
// Rev 1.0
// ============================================================================
`default_nettype none

module diy_mole_table #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 26
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Both updates are non-blocking in one process, so a same-address read sees old data
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/diy_mole_recorder.sv
// ============================================================================
// diy_mole_recorder : records {music_address, location} pairs from pad stomps
// Rev 1.0
// ============================================================================
`default_nettype none

module diy_mole_recorder
  import diy_mole_recorder_pkg::*;
#(
  parameter int          MAX_MOLES  = 128,
  parameter int          INDEX_BITS = 8,
  parameter int          ADDR_BITS  = PKG_ADDR_BITS,
  parameter int unsigned MIN_GAP    = 32'h1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  diy_mode,
  input  logic                  record_active,
  input  logic                  finish,
  input  logic [7:0]            pads,
  input  logic [ADDR_BITS-1:0]  music_address,
  input  logic [INDEX_BITS-1:0] lookup_index,
  output logic [ADDR_BITS-1:0]  index_address,
  output logic [2:0]            saved_mole_location,
  output logic [INDEX_BITS-1:0] total_moles,
  output logic                  ready_to_use,
  output logic                  table_full
);

  localparam int TAB_AW = (MAX_MOLES > 1) ? $clog2(MAX_MOLES) : 1;
  localparam int TAB_DW = ADDR_BITS + 3;
  localparam logic [INDEX_BITS-1:0] MAX_CNT = INDEX_BITS'(MAX_MOLES);
  localparam logic [ADDR_BITS:0]    GAP_EXT = (ADDR_BITS+1)'(MIN_GAP);

  rec_state_t state, next_state;

  logic [7:0]            pads_q;
  logic [INDEX_BITS-1:0] count;
  logic [ADDR_BITS-1:0]  last_addr;
  logic                  ready_q;
  logic                  rd_valid;
  logic [TAB_DW-1:0]     rd_data;

  logic       stomp_edge;
  logic       one_hot;
  logic       gap_ok;
  logic       room;
  logic       done_cond;
  logic       accept;
  logic [2:0] loc;

  assign stomp_edge = (pads_q == 8'd0) && (pads != 8'd0);
  assign one_hot    = $onehot(pads);
  assign room       = (count < MAX_CNT);
  // Extended width keeps last_addr+MIN_GAP from wrapping; a wrapped song address is always rejected
  assign gap_ok     = (count == '0) ||
                      ({1'b0, music_address} >= ({1'b0, last_addr} + GAP_EXT));
  assign done_cond  = (count == MAX_CNT) || (finish && (count != '0));

  always_comb begin
    loc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pads[7-i]) begin
        loc = 3'(i);
      end
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    if (!diy_mode) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (record_active) next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (done_cond) begin
            next_state = ST_DONE;
          end else if (stomp_edge) begin
            accept     = one_hot && room && gap_ok;
            next_state = ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (done_cond)            next_state = ST_DONE;
          else if (pads == 8'd0)    next_state = ST_ARMED;
        end
        ST_DONE: begin
          next_state = ST_DONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pads_q    <= 8'd0;
      count     <= '0;
      last_addr <= '0;
      ready_q   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= next_state;
      pads_q   <= pads;
      ready_q  <= diy_mode && (state == ST_DONE);
      rd_valid <= (lookup_index < count);
      if (!diy_mode || (state == ST_IDLE)) begin
        count     <= '0;
        last_addr <= '0;
      end else if (accept) begin
        count     <= count + 1'b1;
        last_addr <= music_address;
      end
    end
  end

  diy_mole_table #(
    .DEPTH (MAX_MOLES),
    .AW    (TAB_AW),
    .DW    (TAB_DW)
  ) u_table (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count[TAB_AW-1:0]),
    .wr_data ({music_address, loc}),
    .rd_addr (lookup_index[TAB_AW-1:0]),
    .rd_data (rd_data)
  );

  assign index_address       = rd_valid ? rd_data[TAB_DW-1:3] : '0;
  assign saved_mole_location = rd_valid ? rd_data[2:0] : 3'd0;
  assign total_moles         = count;
  assign table_full          = (count == MAX_CNT);
  assign ready_to_use        = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_diy_mole_recorder.sv
// ============================================================================
// tb_diy_mole_recorder : directed + randomized bench with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_diy_mole_recorder;

  localparam int MAXM = 128;
  localparam int IB   = 8;
  localparam int AB   = 23;
  localparam int GAP  = 32'h1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          diy_mode = 1'b0;
  logic          record_active = 1'b0;
  logic          finish = 1'b0;
  logic [7:0]    pads = 8'd0;
  logic [AB-1:0] music_address = '0;
  logic [IB-1:0] lookup_index = '0;
  logic [AB-1:0] index_address;
  logic [2:0]    saved_mole_location;
  logic [IB-1:0] total_moles;
  logic          ready_to_use;
  logic          table_full;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  diy_mole_recorder #(
    .MAX_MOLES(MAXM), .INDEX_BITS(IB), .ADDR_BITS(AB), .MIN_GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .diy_mode(diy_mode), .record_active(record_active),
    .finish(finish), .pads(pads), .music_address(music_address),
    .lookup_index(lookup_index), .index_address(index_address),
    .saved_mole_location(saved_mole_location), .total_moles(total_moles),
    .ready_to_use(ready_to_use), .table_full(table_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 listening for a stomp, 2 waiting for release, 3 closed
  int          m_phase = 0;
  int          m_cnt = 0;
  longint      m_last = 0;
  bit          m_ready = 0;
  logic [7:0]  m_prev = 8'd0;
  int          m_tab_addr [MAXM];
  int          m_tab_loc  [MAXM];
  int          exp_addr = 0;
  int          exp_loc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_last = 0; m_ready = 0; m_prev = 8'd0;
      exp_addr = 0; exp_loc = 0;
    end else begin
      bit closing;
      bit nxt_ready;
      int li;
      li = int'(lookup_index);
      if (li < m_cnt) begin
        exp_addr = m_tab_addr[li];
        exp_loc  = m_tab_loc[li];
      end else begin
        exp_addr = 0;
        exp_loc  = 0;
      end
      nxt_ready = (m_phase == 3) && diy_mode;
      closing = (m_cnt == MAXM) || (finish && m_cnt > 0);
      if (!diy_mode) begin
        m_phase = 0; m_cnt = 0; m_last = 0;
      end else if (m_phase == 0) begin
        m_cnt = 0; m_last = 0;
        if (record_active) m_phase = 1;
      end else if (m_phase == 1 || m_phase == 2) begin
        if (closing) begin
          m_phase = 3;
        end else if (m_phase == 1) begin
          if (m_prev == 8'd0 && pads != 8'd0) begin
            if ($countones(pads) == 1 && m_cnt < MAXM &&
                (m_cnt == 0 || longint'(music_address) >= m_last + GAP)) begin
              for (int b = 0; b < 8; b++)
                if (pads[b]) m_tab_loc[m_cnt] = 7 - b;
              m_tab_addr[m_cnt] = int'(music_address);
              m_last = longint'(music_address);
              m_cnt++;
            end
            m_phase = 2;
          end
        end else if (pads == 8'd0) begin
          m_phase = 1;
        end
      end
      m_ready = nxt_ready;
      m_prev  = pads;
    end
  end

  always @(negedge clk) begin
    chk("total_moles", 32'(total_moles), 32'(m_cnt));
    chk("ready_to_use", 32'(ready_to_use), 32'(m_ready));
    chk("table_full", 32'(table_full), 32'(m_cnt == MAXM));
    chk("index_address", 32'(index_address), 32'(exp_addr));
    chk("saved_mole_location", 32'(saved_mole_location), 32'(exp_loc));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stomp(input logic [7:0] p, input int addr, input int hold);
    music_address = AB'(addr);
    pads = p;
    tick(hold);
    pads = 8'd0;
    tick(2);
  endtask

  task automatic read_at(input int idx, input int a, input int l, input string name);
    lookup_index = IB'(idx);
    tick(1);
    chk({name, "_addr"}, 32'(index_address), 32'(a));
    chk({name, "_loc"}, 32'(saved_mole_location), 32'(l));
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    chk("rst_total", 32'(total_moles), 0);
    chk("rst_ready", 32'(ready_to_use), 0);
    chk("rst_full", 32'(table_full), 0);
    chk("rst_addr", 32'(index_address), 0);
    reset = 1'b0;

    // Two gap-respecting stomps then finish
    diy_mode = 1; record_active = 1;
    tick(2);
    stomp(8'b0100_0000, 32'h8000, 3);
    stomp(8'b0000_1000, 32'h9800, 3);
    finish = 1; tick(1); finish = 0; tick(2);
    chk("t2_total", 32'(total_moles), 2);
    chk("t2_ready", 32'(ready_to_use), 1);
    read_at(1, 32'h9800, 4, "t2_e1");
    read_at(0, 32'h8000, 1, "t2_e0");
    read_at(2, 0, 0, "t2_oob");

    // Drop DIY mode while closed
    diy_mode = 0; tick(1);
    chk("t6_total", 32'(total_moles), 0);
    chk("t6_ready", 32'(ready_to_use), 0);
    read_at(0, 0, 0, "t6_empty");

    // Gap rejection, long hold, wrapped address
    diy_mode = 1; tick(2);
    stomp(8'b0100_0000, 32'h8800, 3);
    stomp(8'b0000_1000, 32'h9000, 3);
    chk("t3_gap_reject", 32'(total_moles), 1);
    stomp(8'b0001_0000, 32'hA000, 1000);
    chk("t3_hold_once", 32'(total_moles), 2);
    stomp(8'b0000_0001, 32'h0100, 3);
    chk("t3_wrap_reject", 32'(total_moles), 2);

    // Multi-hot press and empty finish
    diy_mode = 0; tick(1); diy_mode = 1; tick(2);
    stomp(8'b1100_0000, 32'h1000, 3);
    chk("t4_multihot", 32'(total_moles), 0);
    finish = 1; tick(1); finish = 0; tick(3);
    chk("t4_not_ready", 32'(ready_to_use), 0);
    stomp(8'b0000_0001, 32'h0100, 2);
    chk("t4_still_armed", 32'(total_moles), 1);
    stomp(8'b0000_0010, 32'h2000, 2);
    stomp(8'b0000_0100, 32'h3000, 2);
    chk("t1_pre_reset", 32'(total_moles), 3);

    // Reset mid-record, then re-arm from index 0
    reset = 1; tick(1);
    chk("t1_total", 32'(total_moles), 0);
    chk("t1_ready", 32'(ready_to_use), 0);
    reset = 0; tick(2);
    stomp(8'b0010_0000, 32'h0500, 2);
    read_at(0, 32'h0500, 2, "t1_rearm");

    // Fill the table
    for (int i = 0; i < MAXM - 1; i++)
      stomp(8'h80 >> (i % 8), 32'h2000 + i * 32'h1000, 2);
    tick(2);
    chk("t5_total", 32'(total_moles), MAXM);
    chk("t5_full", 32'(table_full), 1);
    chk("t5_ready", 32'(ready_to_use), 1);
    stomp(8'b0000_0001, 32'h100000, 2);
    chk("t5_frozen", 32'(total_moles), MAXM);
    read_at(MAXM - 1, 32'h2000 + (MAXM - 2) * 32'h1000, (MAXM - 2) % 8, "t5_last");

    // Randomized phase against the model
    diy_mode = 0; tick(1); diy_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) diy_mode = ~diy_mode;
      reset = ($urandom_range(0, 1499) == 0);
      record_active = ($urandom_range(0, 9) != 0);
      finish = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 9) >= 7) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 40)      pads = 8'd0;
        else if (r < 85) pads = 8'h01 << $urandom_range(0, 7);
        else             pads = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) music_address = AB'($urandom_range(0, 32'hFFF));
      else music_address = music_address + AB'($urandom_range(0, 32'h400));
      if ($urandom_range(0, 3) == 0) lookup_index = IB'($urandom);
      else lookup_index = IB'($urandom_range(0, m_cnt + 2));
      tick(1);
    end
    reset = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
